// File: rtl/lbuf_pkg.sv
// Shared constants, types and helpers for the lane-packing SRAM FIFO.
package lbuf_pkg;

  localparam int unsigned LBUF_DEPTH  = 64;
  localparam int unsigned LBUF_AW     = 6;
  localparam int unsigned LBUF_LANES  = 8;
  localparam int unsigned LBUF_LANE_W = 16;
  localparam int unsigned LBUF_WORD_W = 128;

  typedef logic [LBUF_AW-1:0]             lbuf_addr_t;
  typedef logic [LBUF_WORD_W-1:0]         lbuf_word_t;
  typedef logic [LBUF_LANES-1:0]          lbuf_mask_t;
  typedef logic [LBUF_AW:0]               lbuf_cnt_t;
  typedef logic [$clog2(LBUF_LANES)-1:0]  lbuf_lane_t;

  // Lanes fill in order from 0, so a word closed at lane n holds lanes 0..n.
  function automatic lbuf_mask_t lanes_upto(input lbuf_lane_t lane);
    lbuf_mask_t all_lanes;
    all_lanes = '1;
    return all_lanes >> (lbuf_lane_t'(LBUF_LANES - 1) - lane);
  endfunction

endpackage

// File: rtl/lbuf_skid2.sv
// Two-entry register FIFO holding SRAM read words and their lane masks.
module lbuf_skid2
  import lbuf_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  input  lbuf_word_t in_data_i,
  input  lbuf_mask_t in_mask_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output lbuf_word_t out_data_o,
  output lbuf_mask_t out_mask_o,
  output logic [1:0] occ_o
);

  lbuf_word_t data_q [2];
  lbuf_word_t data_d [2];
  lbuf_mask_t mask_q [2];
  lbuf_mask_t mask_d [2];
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic [1:0] occ_q, occ_d;
  logic       pop;

  assign out_valid_o = (occ_q != 2'd0);
  assign pop         = out_valid_o & out_ready_i;
  assign occ_o       = occ_q;
  // Zero when empty so reset and idle both present a clean bus.
  assign out_data_o  = out_valid_o ? data_q[rd_q] : '0;
  assign out_mask_o  = out_valid_o ? mask_q[rd_q] : '0;

  // The producer never pushes into a full buffer, so push needs no ready.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    occ_d  = occ_q;
    if (in_valid_i) begin
      data_d[wr_q] = in_data_i;
      mask_d[wr_q] = in_mask_i;
      wr_d         = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    if (in_valid_i && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (!in_valid_i && pop) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '{default: '0};
      mask_q <= '{default: '0};
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/lbuf_pack_fifo.sv
// Packs 16-bit beats into 128-bit words in a two-port SRAM and streams words out.
// Define LBUF_LANE_MASK_EN to keep per-word lane masks; otherwise out_mask is all-ones.
module lbuf_pack_fifo
  import lbuf_pkg::*;
#(
  parameter int unsigned DEPTH = LBUF_DEPTH,
  parameter int unsigned LANES = LBUF_LANES
) (
  input  logic                   CK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LBUF_LANE_W-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LBUF_WORD_W-1:0] out_data,
  output logic [LBUF_LANES-1:0]  out_mask,
  output logic [LBUF_AW:0]       count,
  output logic [LBUF_AW-1:0]     sram_A,
  output logic [LBUF_LANES-1:0]  sram_WEAN,
  output logic [LBUF_WORD_W-1:0] sram_DIA,
  output logic                   sram_OEA,
  output logic [LBUF_AW-1:0]     sram_B,
  output logic                   sram_OEB,
  output logic [LBUF_LANES-1:0]  sram_WEBN,
  output logic [LBUF_WORD_W-1:0] sram_DIB,
  input  logic [LBUF_WORD_W-1:0] sram_DOB
);

  localparam lbuf_cnt_t  FullCnt  = lbuf_cnt_t'(DEPTH);
  localparam lbuf_lane_t LastLane = lbuf_lane_t'(LANES - 1);

  lbuf_addr_t wr_ptr_q, wr_ptr_d;
  lbuf_addr_t rd_ptr_q, rd_ptr_d;
  lbuf_lane_t lane_q, lane_d;
  lbuf_cnt_t  count_q, count_d;
  logic       inflight_q, inflight_d;
  lbuf_mask_t rd_mask_q, rd_mask_d;
  lbuf_mask_t rd_mask_src;

  logic       accept, commit, issue, pop;
  logic [1:0] skid_occ;
  logic [2:0] out_load;

  assign in_ready = (count_q < FullCnt) && !RST;
  assign accept   = in_valid & in_ready;
  assign commit   = accept & (in_last | (lane_q == LastLane));
  assign pop      = out_valid & out_ready;

  // Words held or about to land in the skid after this cycle's pop must stay below two.
  assign out_load = 3'(skid_occ) + 3'(inflight_q) - 3'(pop);
  // count excludes the word being packed, so a read can never hit the write address.
  assign issue    = !RST && (count_q != '0) && (out_load < 3'd2);

`ifdef LBUF_LANE_MASK_EN
  lbuf_mask_t mask_mem_q [LBUF_DEPTH];

  always_ff @(posedge CK) begin
    if (commit) begin
      mask_mem_q[wr_ptr_q] <= lanes_upto(lane_q);
    end
  end

  assign rd_mask_src = mask_mem_q[rd_ptr_q];
`else
  assign rd_mask_src = '1;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    lane_d     = lane_q;
    count_d    = count_q;
    inflight_d = issue;
    rd_mask_d  = issue ? rd_mask_src : rd_mask_q;
    if (accept) begin
      lane_d = commit ? '0 : lane_q + lbuf_lane_t'(1);
    end
    if (commit) begin
      wr_ptr_d = wr_ptr_q + lbuf_addr_t'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + lbuf_addr_t'(1);
    end
    if (commit && !issue) begin
      count_d = count_q + lbuf_cnt_t'(1);
    end else if (!commit && issue) begin
      count_d = count_q - lbuf_cnt_t'(1);
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lane_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      rd_mask_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lane_q     <= lane_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      rd_mask_q  <= rd_mask_d;
    end
  end

  assign count     = count_q;
  assign sram_A    = wr_ptr_q;
  assign sram_WEAN = accept ? ~(lbuf_mask_t'(1) << lane_q) : '1;
  assign sram_DIA  = {LBUF_LANES{in_data}};
  assign sram_OEA  = 1'b0;
  assign sram_B    = rd_ptr_q;
  assign sram_OEB  = issue;
  assign sram_WEBN = '1;
  assign sram_DIB  = '0;

  lbuf_skid2 u_skid (
    .clk_i      (CK),
    .rst_i      (RST),
    .in_valid_i (inflight_q),
    .in_data_i  (sram_DOB),
    .in_mask_i  (rd_mask_q),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_mask_o (out_mask),
    .occ_o      (skid_occ)
  );

endmodule

// File: tb/tb_lbuf_pack_fifo.sv
// Directed and random checks of lbuf_pack_fifo against a behavioural SRAM.
module tb_lbuf_pack_fifo;

`ifdef LBUF_LANE_MASK_EN
  localparam bit MaskEn = 1'b1;
`else
  localparam bit MaskEn = 1'b0;
`endif

  logic         CK = 1'b0;
  logic         RST;
  logic         in_valid, in_ready, in_last;
  logic [15:0]  in_data;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic [7:0]   out_mask;
  logic [6:0]   count;
  logic [5:0]   sram_A, sram_B;
  logic [7:0]   sram_WEAN, sram_WEBN;
  logic [127:0] sram_DIA, sram_DIB, sram_DOB;
  logic         sram_OEA, sram_OEB;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [127:0] mem [64];
  logic [127:0] dob_q;
  logic [127:0] got_d [$];
  logic [7:0]   got_m [$];
  int           got_c [$];

  lbuf_pack_fifo dut (
    .CK(CK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
    .count(count),
    .sram_A(sram_A), .sram_WEAN(sram_WEAN), .sram_DIA(sram_DIA), .sram_OEA(sram_OEA),
    .sram_B(sram_B), .sram_OEB(sram_OEB), .sram_WEBN(sram_WEBN), .sram_DIB(sram_DIB),
    .sram_DOB(sram_DOB)
  );

  always #5 CK = ~CK;

  initial for (int a = 0; a < 64; a++) mem[a] = '0;

  // Two-port SRAM: lane writes on port A, registered read on port B.
  always @(posedge CK) begin
    for (int l = 0; l < 8; l++) begin
      if (sram_WEAN[l] === 1'b0) mem[sram_A][16*l +: 16] <= sram_DIA[16*l +: 16];
    end
    if (sram_OEB === 1'b1) dob_q <= mem[sram_B];
  end
  assign sram_DOB = dob_q;

  always @(posedge CK) cyc <= cyc + 1;

  always @(negedge CK) begin
    if (RST === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      got_d.push_back(out_data);
      got_m.push_back(out_mask);
      got_c.push_back(cyc);
    end
  end

  always @(negedge CK) begin
    n_cmp++;
    if (sram_WEAN !== 8'hFF && sram_OEB === 1'b1 && sram_A === sram_B) begin
      n_err++;
      $display("FAIL port_collision: A=%0d B=%0d WEAN=%h OEB=1, required A!=B", sram_A, sram_B,
               sram_WEAN);
    end
  end

  task automatic do_reset();
    RST = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge CK);
    #1 RST = 1'b0;
    got_d.delete(); got_m.delete(); got_c.delete();
  endtask

  task automatic put_beat(input logic [15:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge CK);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL beat_accept: in_ready=%b required 1 (data %h)", in_ready, d);
    end
    @(posedge CK); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int g = 0;
    while (got_d.size() < n && g < budget) begin
      @(posedge CK); g++;
    end
    #1;
    n_cmp++;
    if (got_d.size() != n) begin
      n_err++; $display("FAIL %s_word_count: got %0d words, required %0d", name, got_d.size(), n);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; in_valid = 1'b1; in_last = 1'b0; in_data = 16'h1234; out_ready = 1'b1;
    repeat (2) @(posedge CK);
    @(negedge CK);
    n_cmp++;
    if ({in_ready, out_valid, sram_OEB, sram_OEA} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: in_ready/out_valid/OEB/OEA=%b required 0000",
                        {in_ready, out_valid, sram_OEB, sram_OEA});
    end
    n_cmp++;
    if (count !== 7'd0 || out_mask !== 8'h00 || out_data !== 128'h0) begin
      n_err++; $display("FAIL reset_state: count=%0d mask=%h data=%h required 0/00/0",
                        count, out_mask, out_data);
    end
    n_cmp++;
    if (sram_WEAN !== 8'hFF || sram_WEBN !== 8'hFF || sram_DIB !== 128'h0) begin
      n_err++; $display("FAIL reset_sram: WEAN=%h WEBN=%h DIB=%h required FF/FF/0",
                        sram_WEAN, sram_WEBN, sram_DIB);
    end
    @(posedge CK); #1;
    RST = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge CK);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_full_word();
    logic [7:0]   wean_exp [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [127:0] word_exp = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i + 1); in_last = 1'b0;
      @(negedge CK);
      n_cmp++;
      if (sram_A !== 6'd0 || sram_WEAN !== wean_exp[i]) begin
        n_err++; $display("FAIL full_wean[%0d]: A=%0d WEAN=%h required A=0 WEAN=%h", i, sram_A,
                          sram_WEAN, wean_exp[i]);
      end
      @(posedge CK); #1;
    end
    in_valid = 1'b0;
    @(negedge CK);
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 7'd1 || sram_OEB !== 1'b1 || sram_B !== 6'd0) begin
      n_err++; $display("FAIL full_edge1: valid=%b count=%0d OEB=%b B=%0d required 0/1/1/0",
                        out_valid, count, sram_OEB, sram_B);
    end
    @(posedge CK); @(negedge CK);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL full_latency_early: out_valid=%b one edge after commit, required 0",
                        out_valid);
    end
    @(posedge CK); @(negedge CK);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL full_latency: out_valid=%b two edges after commit, required 1",
                        out_valid);
    end
    n_cmp++;
    if (out_data !== word_exp || out_mask !== 8'hFF) begin
      n_err++; $display("FAIL full_word: data=%h mask=%h required %h/FF", out_data, out_mask,
                        word_exp);
    end
    @(posedge CK); #1 out_ready = 1'b1;
    @(posedge CK); #1 out_ready = 1'b0;
    @(negedge CK);
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 7'd0) begin
      n_err++; $display("FAIL full_drain: valid=%b count=%0d required 0/0", out_valid, count);
    end
  endtask

  task automatic test_partial_word();
    int g = 0;
    logic [7:0] mask_exp;
    mask_exp = MaskEn ? 8'h07 : 8'hFF;
    do_reset();
    put_beat(16'h000A, 1'b0);
    put_beat(16'h000B, 1'b0);
    put_beat(16'h000C, 1'b1);
    @(negedge CK);
    while (out_valid !== 1'b1 && g < 10) begin
      @(negedge CK); g++;
    end
    n_cmp++;
    if (out_mask !== mask_exp || out_data[47:0] !== 48'h000C_000B_000A) begin
      n_err++; $display("FAIL partial_word: mask=%h lanes0-2=%h required %h/000c000b000a",
                        out_mask, out_data[47:0], mask_exp);
    end
    @(posedge CK); #1;
    in_valid = 1'b1; in_data = 16'h000D;
    @(negedge CK);
    n_cmp++;
    if (sram_A !== 6'd1 || sram_WEAN !== 8'hFE) begin
      n_err++; $display("FAIL partial_next: A=%0d WEAN=%h required 1/FE", sram_A, sram_WEAN);
    end
    @(posedge CK); #1 in_valid = 1'b0;
  endtask

  task automatic test_fill();
    logic [127:0] w;
    int stalls = 0;
    do_reset();
    for (int i = 0; i < 528; i++) begin
      in_valid = 1'b1; in_data = 16'(i); in_last = 1'b0;
      @(negedge CK);
      if (in_ready !== 1'b1) stalls++;
      @(posedge CK); #1;
    end
    in_valid = 1'b0;
    @(negedge CK);
    n_cmp++;
    if (stalls != 0) begin
      n_err++; $display("FAIL fill_stalls: %0d beats refused, required 0", stalls);
    end
    n_cmp++;
    if (in_ready !== 1'b0 || count !== 7'd64 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL fill_full: in_ready=%b count=%0d valid=%b required 0/64/1",
                        in_ready, count, out_valid);
    end
    repeat (3) @(negedge CK);
    n_cmp++;
    if (out_data !== 128'h0007_0006_0005_0004_0003_0002_0001_0000) begin
      n_err++; $display("FAIL fill_hold: data=%h required word 0 held", out_data);
    end
    @(posedge CK); #1 out_ready = 1'b1;
    wait_words(66, 200, "fill");
    for (int k = 0; k < got_d.size(); k++) begin
      for (int l = 0; l < 8; l++) w[16*l +: 16] = 16'(8 * k + l);
      n_cmp++;
      if (got_d[k] !== w || got_m[k] !== 8'hFF) begin
        n_err++; $display("FAIL fill_word[%0d]: data=%h mask=%h required %h/FF", k, got_d[k],
                          got_m[k], w);
      end
    end
    n_cmp++;
    if (got_c.size() == 0 || got_c[got_c.size()-1] - got_c[0] != 65) begin
      n_err++; $display("FAIL fill_throughput: drain span not 66 consecutive cycles");
    end
    @(negedge CK);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL fill_ready_back: in_ready=%b required 1", in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [6:0]   cnt_b, cnt_exp;
    logic         oeb_b, cmt;
    logic [127:0] w;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      in_valid = 1'b1; in_data = 16'(i * 7 + 3); in_last = 1'b0;
      @(negedge CK);
      n_cmp++;
      if (in_ready !== 1'b1 || sram_A !== 6'((i / 8) % 64) ||
          sram_WEAN !== ~(8'h01 << (i % 8))) begin
        n_err++; $display("FAIL wrap_write[%0d]: rdy=%b A=%0d WEAN=%h required 1/%0d/%h", i,
                          in_ready, sram_A, sram_WEAN, (i / 8) % 64, ~(8'h01 << (i % 8)));
      end
      cnt_b = count; oeb_b = sram_OEB; cmt = (i % 8 == 7);
      cnt_exp = cnt_b + 7'(cmt) - 7'(oeb_b);
      @(posedge CK); #1;
      n_cmp++;
      if (count !== cnt_exp) begin
        n_err++; $display("FAIL wrap_count[%0d]: count=%0d required %0d", i, count, cnt_exp);
      end
    end
    in_valid = 1'b0;
    wait_words(200, 100, "wrap");
    for (int k = 0; k < got_d.size(); k++) begin
      for (int l = 0; l < 8; l++) w[16*l +: 16] = 16'((8 * k + l) * 7 + 3);
      n_cmp++;
      if (got_d[k] !== w) begin
        n_err++; $display("FAIL wrap_word[%0d]: data=%h required %h", k, got_d[k], w);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 19; i++) put_beat(16'(i + 1), 1'b0);
    @(negedge CK);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: out_valid=%b required 1", out_valid);
    end
    @(posedge CK); #1 RST = 1'b1;
    @(posedge CK); #1 RST = 1'b0;
    in_valid = 1'b1; in_data = 16'h0055;
    @(negedge CK);
    n_cmp++;
    if (count !== 7'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_state: count=%0d valid=%b required 0/0", count, out_valid);
    end
    n_cmp++;
    if (sram_A !== 6'd0 || sram_WEAN !== 8'hFE) begin
      n_err++; $display("FAIL rstmid_beat: A=%0d WEAN=%h required 0/FE", sram_A, sram_WEAN);
    end
    @(posedge CK); #1 in_valid = 1'b0;
    repeat (3) @(negedge CK);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_discard: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [127:0] exp_d [$];
    logic [7:0]   exp_m [$];
    logic [127:0] cur_w, m128;
    logic [7:0]   cur_m, em;
    int           ln = 0;
    do_reset();
    cur_w = '0; cur_m = '0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      in_last   = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 2) == 0);
      @(negedge CK);
      if (in_valid && in_ready === 1'b1) begin
        cur_w[16*ln +: 16] = in_data;
        cur_m[ln] = 1'b1;
        if (in_last || ln == 7) begin
          exp_d.push_back(cur_w); exp_m.push_back(cur_m);
          cur_m = '0; ln = 0;
        end else begin
          ln++;
        end
      end
      @(posedge CK); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    wait_words(exp_d.size(), 200, "random");
    for (int k = 0; k < got_d.size() && k < exp_d.size(); k++) begin
      for (int l = 0; l < 8; l++) m128[16*l +: 16] = {16{exp_m[k][l]}};
      em = MaskEn ? exp_m[k] : 8'hFF;
      n_cmp++;
      if ((got_d[k] & m128) !== (exp_d[k] & m128) || got_m[k] !== em) begin
        n_err++; $display("FAIL random_word[%0d]: data=%h mask=%h required %h/%h", k,
                          got_d[k] & m128, got_m[k], exp_d[k] & m128, em);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_word();
    test_fill();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
